prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 25 ++
 rtl/prog_loader.sv | 131 +++++++++++++
 2 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader.
// Holds the loader state encoding, default widths and the byte field masks
// used to reject malformed length-high and instruction-high bytes.
package prog_loader_pkg;

  localparam int AW_DEF = 10;
  localparam int IW_DEF = 9;

  // Bits that must be zero in the LEN_HI byte (only bits [1:0] carry length).
  localparam logic [7:0] LEN_HI_MASK = 8'hFC;
  // Bits that must be zero in an instruction HI byte (only bit 0 is used).
  localparam logic [7:0] INS_HI_MASK = 8'hFE;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_INS_LO = 3'd2,
    S_INS_HI = 3'd3,
    S_WRITE  = 3'd4,
    S_CHK    = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Program loader: receives a byte stream (LEN_LO, LEN_HI, N x {LO, HI}, CHK),
// writes N instruction words into instruction memory at addresses 0..N-1,
// checks an XOR checksum over all non-CHK bytes, and releases the processor
// (cpu_start low) only after a good load.
//
// Ports:
//   CLK          - clock, all state updates on posedge
//   reset        - asynchronous active-high reset
//   rx_data      - incoming program byte
//   rx_valid     - rx_data is valid
//   rx_ready     - loader accepts a byte this cycle
//   imem_wr_en   - instruction-memory write strobe (one cycle per word)
//   imem_addr    - instruction-memory address (the word index register)
//   imem_wr_data - assembled instruction word {HI[0], LO}
//   cpu_start    - processor init/hold, high until a good load completes
//   load_done    - program loaded and checksum good
//   load_err     - format or checksum error, sticky until reset
//   dbg_state    - current FSM state, for observation only
//
// Handshake: a byte is transferred on a posedge where rx_valid && rx_ready.
// rx_valid may be dropped at any time; the loader then holds its state.
// rx_ready is registered and depends only on the state, never on rx_valid.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          imem_wr_en,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wr_data,
  output logic          cpu_start,
  output logic          load_done,
  output logic          load_err,
  output state_t        dbg_state
);

  state_t        state_q;
  state_t        state_d;
  logic [9:0]    len_q;
  logic [AW-1:0] idx_q;
  logic [7:0]    xor_q;
  logic [IW-1:0] word_q;
  logic          accept;
  logic          last_word;

  assign accept       = rx_valid && rx_ready;
  // The index stops at N-1, so the last write is detected by equality.
  assign last_word    = (idx_q == AW'(len_q - 10'd1));
  assign imem_addr    = idx_q;
  assign imem_wr_data = word_q;
  assign dbg_state    = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN_LO: if (accept) state_d = S_LEN_HI;
      S_LEN_HI: if (accept) begin
        if ((rx_data & LEN_HI_MASK) != 8'h00)        state_d = S_ERR;
        else if ({rx_data[1:0], len_q[7:0]} == 10'd0) state_d = S_CHK;
        else                                          state_d = S_INS_LO;
      end
      S_INS_LO: if (accept) state_d = S_INS_HI;
      S_INS_HI: if (accept) begin
        if ((rx_data & INS_HI_MASK) != 8'h00) state_d = S_ERR;
        else                                  state_d = S_WRITE;
      end
      // WRITE consumes no byte, so it advances unconditionally.
      S_WRITE:  state_d = last_word ? S_CHK : S_INS_LO;
      S_CHK:    if (accept) state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
      S_DONE:   state_d = S_DONE;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_ERR;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= S_LEN_LO;
      len_q      <= '0;
      idx_q      <= '0;
      xor_q      <= '0;
      word_q     <= '0;
      rx_ready   <= 1'b1;
      imem_wr_en <= 1'b0;
      cpu_start  <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state_q <= state_d;

      // Outputs are decoded from the next state so they line up with state_q.
      rx_ready   <= (state_d inside {S_LEN_LO, S_LEN_HI, S_INS_LO, S_INS_HI, S_CHK});
      imem_wr_en <= (state_d == S_WRITE);
      cpu_start  <= (state_d != S_DONE);
      load_done  <= (state_d == S_DONE);
      load_err   <= (state_d == S_ERR);

      if (accept) begin
        case (state_q)
          S_LEN_LO: begin
            len_q[7:0] <= rx_data;
            xor_q      <= xor_q ^ rx_data;
          end
          S_LEN_HI: begin
            len_q[9:8] <= rx_data[1:0];
            xor_q      <= xor_q ^ rx_data;
          end
          S_INS_LO: begin
            word_q[7:0] <= rx_data;
            xor_q       <= xor_q ^ rx_data;
          end
          S_INS_HI: begin
            word_q[8] <= rx_data[0];
            xor_q     <= xor_q ^ rx_data;
          end
          default: ;
        endcase
      end

      // Advance only when more words follow, so the index never passes N-1.
      if (state_q == S_WRITE && !last_word) idx_q <= idx_q + AW'(1);
    end
  end

endmodule
